// File: rtl/sorter_pkg.sv
// Shared types for the sorter front end: scheduler states, the job length
// type and the width helper for the chunk count.
package sorter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONFIG  = 3'd1,
    START   = 3'd2,
    RUN     = 3'd3,
    RELEASE = 3'd4
  } sched_state_t;

  typedef logic [15:0] job_len_t;

  // Width of the chunk count: must hold max_len / base itself, so one bit
  // more than the log of the ratio.
  function automatic int chunk_w(input int max_len, input int base);
    return $clog2(max_len / base) + 1;
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Rotating-priority encoder: picks the first asserted request at or above
// rr_ptr, wrapping around. Purely combinational.
module round_robin_arbiter
  import sorter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_id,
  output logic             any_valid
);

  // Walk the requests starting from the pointer; the first hit wins.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    winner_id = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!any_valid && req[idx]) begin
        any_valid   = 1'b1;
        winner[idx] = 1'b1;
        winner_id   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sorter_job_scheduler.sv
// Sorter job scheduler: round-robin grants the shared sorter to one
// requester at a time, converts the job length into chunk count / last
// chunk size, pulses sorter_start and holds the grant until sorter_done.
// Optional watchdog on the RUN state: define SORT_SCHEDULER_TIMEOUT_EN.
module sorter_job_scheduler
  import sorter_pkg::*;
#(
  parameter int N_REQUESTERS    = 4,
  parameter int MAX_SORT_LENGTH = 32,
  parameter int BASE_CHUNK_SIZE = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                                   clock,
  input  logic                                                   reset,
  input  logic [N_REQUESTERS-1:0]                                req_valid,
  input  logic [16*N_REQUESTERS-1:0]                             req_length,
  output logic [N_REQUESTERS-1:0]                                req_ready,
  output logic [N_REQUESTERS-1:0]                                grant,
  output logic [$clog2(N_REQUESTERS)-1:0]                        grant_id,
  output logic [chunk_w(MAX_SORT_LENGTH, BASE_CHUNK_SIZE)-1:0]   n_chunks,
  output logic [$clog2(BASE_CHUNK_SIZE)-1:0]                     last_chunk_size,
  output logic                                                   sorter_start,
  input  logic                                                   sorter_done,
  output logic                                                   busy,
  output logic                                                   job_reject,
  output logic                                                   job_timeout
);

  localparam int       ID_W     = $clog2(N_REQUESTERS);
  localparam int       CHUNK_W  = chunk_w(MAX_SORT_LENGTH, BASE_CHUNK_SIZE);
  localparam int       LOG_BASE = $clog2(BASE_CHUNK_SIZE);
  localparam job_len_t MAX_LEN  = job_len_t'(MAX_SORT_LENGTH);

  sched_state_t        state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     rr_next;
  job_len_t            job_len;
  job_len_t            win_len;
  logic [N_REQUESTERS-1:0] arb_winner;
  logic [ID_W-1:0]     arb_id;
  logic                arb_any;

`ifdef SORT_SCHEDULER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] run_count;
`endif

  round_robin_arbiter #(
    .N     (N_REQUESTERS),
    .IDX_W (ID_W)
  ) u_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (arb_winner),
    .winner_id (arb_id),
    .any_valid (arb_any)
  );

  // Length lane of the current arbitration winner and the pointer value
  // that follows the granted requester.
  always_comb begin
    win_len = req_length[16*int'(arb_id) +: 16];
    rr_next = (grant_id == ID_W'(N_REQUESTERS - 1)) ? '0 : grant_id + 1'b1;
  end

  // Scheduler FSM; every output is registered and pulses default low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      job_len         <= '0;
      grant           <= '0;
      grant_id        <= '0;
      req_ready       <= '0;
      n_chunks        <= '0;
      last_chunk_size <= '0;
      sorter_start    <= 1'b0;
      busy            <= 1'b0;
      job_reject      <= 1'b0;
`ifdef SORT_SCHEDULER_TIMEOUT_EN
      job_timeout     <= 1'b0;
      run_count       <= '0;
`endif
    end else begin
      req_ready    <= '0;
      sorter_start <= 1'b0;
      job_reject   <= 1'b0;
`ifdef SORT_SCHEDULER_TIMEOUT_EN
      job_timeout  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (arb_any) begin
            job_len         <= win_len;
            grant           <= arb_winner;
            grant_id        <= arb_id;
            req_ready       <= arb_winner;
            n_chunks        <= CHUNK_W'(win_len >> LOG_BASE);
            last_chunk_size <= win_len[LOG_BASE-1:0];
            busy            <= 1'b1;
            state           <= CONFIG;
          end
        end
        CONFIG: begin
          if (job_len == '0 || job_len > MAX_LEN) begin
            job_reject <= 1'b1;
            state      <= RELEASE;
          end else begin
            sorter_start <= 1'b1;
            state        <= START;
          end
        end
        START: begin
`ifdef SORT_SCHEDULER_TIMEOUT_EN
          run_count <= '0;
`endif
          state <= RUN;
        end
        RUN: begin
          if (sorter_done) begin
            state <= RELEASE;
          end
`ifdef SORT_SCHEDULER_TIMEOUT_EN
          else if (run_count == TIMEOUT_LAST) begin
            job_timeout <= 1'b1;
            state       <= RELEASE;
          end else begin
            run_count <= run_count + 16'd1;
          end
`endif
        end
        RELEASE: begin
          grant           <= '0;
          rr_ptr          <= rr_next;
          busy            <= 1'b0;
          n_chunks        <= '0;
          last_chunk_size <= '0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SORT_SCHEDULER_TIMEOUT_EN
  // Watchdog compiled out: the output stays low for any legal TIMEOUT_CYCLES.
  assign job_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule
